// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the decoded cell-press outputs feeding the game top.
// Latency: none (wires only).
// Backpressure: none; press pulses are fire-and-forget single-cycle strobes.
interface keypad_scanner_if;
    logic [2:0] col_n;      // columns, active-low, bit 0 = left
    logic [2:0] row_n;      // row drive, active-low, bit 0 = top
    logic       a_button;
    logic       b_button;
    logic       c_button;
    logic       d_button;
    logic       e_button;
    logic       f_button;
    logic       g_button;
    logic       h_button;
    logic       i_button;
    logic [3:0] key_code;   // last accepted key 1..9, 0 after reset
    logic       key_held;

    // Scanner side: drives the rows and the decoded outputs.
    modport master (
        input  col_n,
        output row_n,
        output a_button, b_button, c_button, d_button, e_button,
        output f_button, g_button, h_button, i_button,
        output key_code, key_held
    );

    // Board/game side: drives the columns and consumes the decoded outputs.
    modport slave (
        output col_n,
        input  row_n,
        input  a_button, b_button, c_button, d_button, e_button,
        input  f_button, g_button, h_button, i_button,
        input  key_code, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 3x3 keypad row scanner with frame-level debounce; KEYPAD_SYNC_EN adds a 2-flop column synchronizer.
// Latency: press pulse one cycle after the DEBOUNCE_CNT-th matching frame end (+2 with KEYPAD_SYNC_EN).
// Backpressure: none; each accepted press yields exactly one single-cycle pulse, no queuing.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    keypad_scanner_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, WAIT_REL} state_t;

    logic [2:0]    col_s;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    row_sel;
    logic          slot_last;
    logic          frame_end;
    logic [2:0]    row0_hit;
    logic [2:0]    row1_hit;
    logic [8:0]    frame_bits;
    logic [3:0]    frame_code;
    logic [3:0]    hits;
    logic          code_valid;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] stable_q, stable_d;
    logic [3:0]    key_code_q, key_code_d;

`ifdef KEYPAD_SYNC_EN
    logic [2:0] sync_q1;
    logic [2:0] sync_q2;

    // Two-stage synchronizer on the asynchronous column inputs (idle = released).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 3'b111;
            sync_q2 <= 3'b111;
        end else begin
            sync_q1 <= kp.col_n;
            sync_q2 <= sync_q1;
        end
    end
    assign col_s = sync_q2;
`else
    assign col_s = kp.col_n;
`endif

    assign slot_last = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame_end = slot_last && (row_sel == 2'd2);

    // Row ring: each row held for SCAN_DIV cycles, stepping 0->1->2->0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            row_sel  <= 2'd0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            row_sel  <= (row_sel == 2'd2) ? 2'd0 : row_sel + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // Capture rows 0 and 1 on their last slot cycle; row 2 is consumed live at frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row0_hit <= 3'b000;
            row1_hit <= 3'b000;
        end else if (slot_last) begin
            if (row_sel == 2'd0) row0_hit <= ~col_s;
            if (row_sel == 2'd1) row1_hit <= ~col_s;
        end
    end

    assign frame_bits = {~col_s, row1_hit, row0_hit};

    // Reduce the nine key bits to 0 (none), 1..9 (single key) or 15 (multiple keys).
    always_comb begin
        hits       = 4'd0;
        frame_code = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (frame_bits[i]) begin
                hits       = hits + 4'd1;
                frame_code = 4'(i + 1);
            end
        end
        if (hits > 4'd1) frame_code = 4'd15;
    end

    assign code_valid = (frame_code != 4'd0) && (frame_code != 4'd15);

    // FSM state, candidate key, stable-frame counter and accepted key code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cand_q     <= 4'd0;
            stable_q   <= '0;
            key_code_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            key_code_q <= key_code_d;
        end
    end

    // Next-state: debounce presses and releases one frame at a time.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        key_code_d = key_code_q;
        case (state_q)
            IDLE: begin
                if (frame_end && code_valid) begin
                    cand_d = frame_code;
                    if (DEBOUNCE_CNT == 1) begin
                        state_d    = EMIT;
                        stable_d   = '0;
                        key_code_d = frame_code;
                    end else begin
                        state_d  = DEBOUNCE;
                        stable_d = CW'(1);
                    end
                end
            end
            DEBOUNCE: begin
                if (frame_end) begin
                    if (frame_code == cand_q) begin
                        if (stable_q + CW'(1) == CW'(DEBOUNCE_CNT)) begin
                            state_d    = EMIT;
                            stable_d   = '0;
                            key_code_d = cand_q;
                        end else begin
                            stable_d = stable_q + CW'(1);
                        end
                    end else if (code_valid) begin
                        cand_d   = frame_code;
                        stable_d = CW'(1);
                    end else begin
                        state_d  = IDLE;
                        stable_d = '0;
                    end
                end
            end
            EMIT: begin
                state_d  = WAIT_REL;
                stable_d = '0;
            end
            WAIT_REL: begin
                if (frame_end) begin
                    if (frame_code == 4'd0) begin
                        if (stable_q + CW'(1) == CW'(DEBOUNCE_CNT)) begin
                            state_d  = IDLE;
                            stable_d = '0;
                        end else begin
                            stable_d = stable_q + CW'(1);
                        end
                    end else begin
                        stable_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                stable_d = '0;
            end
        endcase
    end

    // Outputs: row drive, one-hot press pulse during EMIT, held flag and key code.
    always_comb begin
        case (row_sel)
            2'd0:    kp.row_n = 3'b110;
            2'd1:    kp.row_n = 3'b101;
            default: kp.row_n = 3'b011;
        endcase
        kp.a_button = (state_q == EMIT) && (cand_q == 4'd1);
        kp.b_button = (state_q == EMIT) && (cand_q == 4'd2);
        kp.c_button = (state_q == EMIT) && (cand_q == 4'd3);
        kp.d_button = (state_q == EMIT) && (cand_q == 4'd4);
        kp.e_button = (state_q == EMIT) && (cand_q == 4'd5);
        kp.f_button = (state_q == EMIT) && (cand_q == 4'd6);
        kp.g_button = (state_q == EMIT) && (cand_q == 4'd7);
        kp.h_button = (state_q == EMIT) && (cand_q == 4'd8);
        kp.i_button = (state_q == EMIT) && (cand_q == 4'd9);
        kp.key_held = (state_q == EMIT) || (state_q == WAIT_REL);
        kp.key_code = key_code_q;
    end
endmodule
